counter_watermark_irq: RTL and testbench

//  Sits directly downstream of delta_counter. Watches its count value (q_o) and

---
 rtl/counter_watermark_irq.sv | 131 +++++++++++++
 tb/tb_counter_watermark_irq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_watermark_irq.sv
// Watermark/overflow interrupt watcher for the delta_counter value and overflow flag.
// Latency: a condition seen in cycle t sets pend_o/irq_o at the edge ending t (1 cycle).
// Backpressure: none; events are always accepted, and repeats of an already-pending cause are counted as missed.
//
// Ports:
//    clk_i, rst_i      clock, synchronous active-high reset
//    cfg_en_i          watcher enable
//    cfg_hi_i/lo_i     high/low watermarks (unsigned, lo < hi required)
//    cnt_i, cnt_ovf_i  counter value and overflow flag from delta_counter
//    ack_i             W1C acknowledge: [0] HI, [1] LO, [2] OVF
//    clr_miss_i        clears the missed-event counter
//    irq_o             OR of pending bits (registered)
//    pend_o            pending causes: [0] HI, [1] LO, [2] OVF
//    miss_cnt_o        saturating count of events lost while already pending
//    cfg_err_o         combinational: cfg_lo_i >= cfg_hi_i
module counter_watermark_irq #(
   parameter int WIDTH  = 4,
   parameter int MISS_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cfg_en_i,
   input  logic [WIDTH-1:0]  cfg_hi_i,
   input  logic [WIDTH-1:0]  cfg_lo_i,
   input  logic [WIDTH-1:0]  cnt_i,
   input  logic              cnt_ovf_i,
   input  logic [2:0]        ack_i,
   input  logic              clr_miss_i,
   output logic              irq_o,
   output logic [2:0]        pend_o,
   output logic [MISS_W-1:0] miss_cnt_o,
   output logic              cfg_err_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM_HI = 2'd1,
      ARM_LO = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_n;
   logic [2:0]          r_pend;
   logic                r_irq;
   logic [MISS_W-1:0]   r_miss;
   logic                r_ovf_q;

   logic                w_cfg_err;
   logic                w_active;
   logic                w_ge_hi;
   logic                w_le_lo;
   logic                w_ev_hi;
   logic                w_ev_lo;
   logic                w_ev_ovf;
   logic [2:0]          w_ev;
   logic [2:0]          w_pend_n;
   logic [2:0]          w_miss_vec;
   logic [1:0]          w_miss_add;
   logic [MISS_W-1:0]   w_miss_base;
   logic [MISS_W:0]     w_miss_sum;
   logic [MISS_W-1:0]   w_miss_n;

   assign w_cfg_err = (cfg_lo_i >= cfg_hi_i);
   assign w_active  = cfg_en_i & ~w_cfg_err;
   assign w_ge_hi   = (cnt_i >= cfg_hi_i);
   assign w_le_lo   = (cnt_i <= cfg_lo_i);

   // Hysteresis FSM: only a crossing from the armed side raises an event;
   // arming out of IDLE picks the side from the current value silently.
   always_comb begin
      w_state_n = r_state;
      w_ev_hi   = 1'b0;
      w_ev_lo   = 1'b0;
      if (!w_active) begin
         w_state_n = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_n = w_ge_hi ? ARM_LO : ARM_HI;
            ARM_HI: begin
               if (w_ge_hi) begin
                  w_ev_hi   = 1'b1;
                  w_state_n = ARM_LO;
               end
            end
            ARM_LO: begin
               if (w_le_lo) begin
                  w_ev_lo   = 1'b1;
                  w_state_n = ARM_HI;
               end
            end
            default: w_state_n = IDLE;
         endcase
      end
   end

   // Overflow is edge-detected so a sticky overflow flag yields one event.
   assign w_ev_ovf = cfg_en_i & cnt_ovf_i & ~r_ovf_q;
   assign w_ev     = {w_ev_ovf, w_ev_lo, w_ev_hi};

   // Set beats ack when both hit the same bit in one cycle.
   assign w_pend_n = (r_pend & ~ack_i) | w_ev;

   // An event is lost only if its bit stays pending (not acked this cycle).
   assign w_miss_vec  = w_ev & r_pend & ~ack_i;
   assign w_miss_add  = {1'b0, w_miss_vec[0]} + {1'b0, w_miss_vec[1]} + {1'b0, w_miss_vec[2]};
   assign w_miss_base = clr_miss_i ? '0 : r_miss;
   assign w_miss_sum  = {1'b0, w_miss_base} + {{(MISS_W-1){1'b0}}, w_miss_add};
   assign w_miss_n    = w_miss_sum[MISS_W] ? {MISS_W{1'b1}} : w_miss_sum[MISS_W-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_pend  <= '0;
         r_irq   <= 1'b0;
         r_miss  <= '0;
         r_ovf_q <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pend  <= w_pend_n;
         r_irq   <= |w_pend_n;
         r_miss  <= w_miss_n;
         r_ovf_q <= cnt_ovf_i;
      end
   end

   assign irq_o      = r_irq;
   assign pend_o     = r_pend;
   assign miss_cnt_o = r_miss;
   assign cfg_err_o  = w_cfg_err;

endmodule

// File: tb/tb_counter_watermark_irq.sv
// Self-checking bench for counter_watermark_irq (WIDTH=4, MISS_W=8).
// Directed table, hand-written corner sequences, then randomized stimulus.
// Every cycle is also compared against a behavioural model of the watcher.
module tb_counter_watermark_irq;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       cfg_en_i;
   logic [3:0] cfg_hi_i;
   logic [3:0] cfg_lo_i;
   logic [3:0] cnt_i;
   logic       cnt_ovf_i;
   logic [2:0] ack_i;
   logic       clr_miss_i;
   logic       irq_o;
   logic [2:0] pend_o;
   logic [7:0] miss_cnt_o;
   logic       cfg_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   counter_watermark_irq #(.WIDTH(4), .MISS_W(8)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cfg_en_i   (cfg_en_i),
      .cfg_hi_i   (cfg_hi_i),
      .cfg_lo_i   (cfg_lo_i),
      .cnt_i      (cnt_i),
      .cnt_ovf_i  (cnt_ovf_i),
      .ack_i      (ack_i),
      .clr_miss_i (clr_miss_i),
      .irq_o      (irq_o),
      .pend_o     (pend_o),
      .miss_cnt_o (miss_cnt_o),
      .cfg_err_o  (cfg_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural model: which watermark the watcher is waiting for
   // (0 = not watching, 1 = waiting to reach hi, 2 = waiting to fall to lo),
   // pending causes, missed-event total and last overflow level.
   int m_wait;
   int m_pend[3];
   int m_miss;
   int m_ovf_last;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int ev[3];
      int lost;
      bit watching;
      for (int i = 0; i < 3; i++) ev[i] = 0;
      if (rst_i) begin
         m_wait = 0; m_miss = 0; m_ovf_last = 0;
         for (int i = 0; i < 3; i++) m_pend[i] = 0;
         return;
      end
      watching = cfg_en_i && (int'(cfg_lo_i) < int'(cfg_hi_i));
      if (!watching) m_wait = 0;
      else if (m_wait == 0) m_wait = (int'(cnt_i) >= int'(cfg_hi_i)) ? 2 : 1;
      else if (m_wait == 1 && int'(cnt_i) >= int'(cfg_hi_i)) begin ev[0] = 1; m_wait = 2; end
      else if (m_wait == 2 && int'(cnt_i) <= int'(cfg_lo_i)) begin ev[1] = 1; m_wait = 1; end
      if (cfg_en_i && cnt_ovf_i && m_ovf_last == 0) ev[2] = 1;
      m_ovf_last = cnt_ovf_i;
      lost = 0;
      for (int i = 0; i < 3; i++) begin
         if (ev[i] == 1 && m_pend[i] == 1 && !ack_i[i]) lost++;
         if (ack_i[i]) m_pend[i] = 0;
         if (ev[i] == 1) m_pend[i] = 1;
      end
      if (clr_miss_i) m_miss = 0;
      m_miss = (m_miss + lost > 255) ? 255 : m_miss + lost;
   endtask

   // One clock: advance the model with the inputs held across the edge,
   // then sample the DUT 1 time unit after the edge and compare.
   task automatic step();
      int mp;
      model_step();
      @(posedge clk_i);
      #1;
      mp = m_pend[2] * 4 + m_pend[1] * 2 + m_pend[0];
      check("model_pend", int'(pend_o), mp);
      check("model_irq", int'(irq_o), (mp != 0) ? 1 : 0);
      check("model_miss", int'(miss_cnt_o), m_miss);
      check("cfg_err", int'(cfg_err_o), (cfg_lo_i >= cfg_hi_i) ? 1 : 0);
   endtask

   typedef struct {
      logic [3:0] cnt;
      logic [2:0] ack;
      logic [2:0] exp_pend;
      logic       exp_irq;
      logic [7:0] exp_miss;
   } vec_t;

   vec_t tbl[18];

   initial begin
      // Ramp 0..15 (one HI at 12, none at 13..15), fall to 3 (LO), then ack both.
      for (int i = 0; i < 16; i++) begin
         tbl[i].cnt      = 4'(i);
         tbl[i].ack      = 3'b000;
         tbl[i].exp_pend = (i >= 12) ? 3'b001 : 3'b000;
         tbl[i].exp_irq  = (i >= 12);
         tbl[i].exp_miss = 8'd0;
      end
      tbl[16] = '{cnt: 4'd3, ack: 3'b000, exp_pend: 3'b011, exp_irq: 1'b1, exp_miss: 8'd0};
      tbl[17] = '{cnt: 4'd3, ack: 3'b011, exp_pend: 3'b000, exp_irq: 1'b0, exp_miss: 8'd0};

      rst_i = 1'b1; cfg_en_i = 1'b0; cfg_hi_i = 4'd12; cfg_lo_i = 4'd3;
      cnt_i = 4'd0; cnt_ovf_i = 1'b0; ack_i = 3'b000; clr_miss_i = 1'b0;
      step();
      check("reset_pend", int'(pend_o), 0);
      check("reset_irq", int'(irq_o), 0);
      check("reset_miss", int'(miss_cnt_o), 0);
      rst_i = 1'b0; cfg_en_i = 1'b1;

      for (int i = 0; i < 18; i++) begin
         cnt_i = tbl[i].cnt; ack_i = tbl[i].ack;
         step();
         check($sformatf("tbl%0d_pend", i), int'(pend_o), int'(tbl[i].exp_pend));
         check($sformatf("tbl%0d_irq", i), int'(irq_o), int'(tbl[i].exp_irq));
         check($sformatf("tbl%0d_miss", i), int'(miss_cnt_o), int'(tbl[i].exp_miss));
      end
      ack_i = 3'b000;

      // Repeated HI without ack counts as a miss, then saturation.
      cnt_i = 4'd12; step();
      cnt_i = 4'd3;  step();
      cnt_i = 4'd12; step();
      check("hi_miss_one", int'(miss_cnt_o), 1);
      for (int i = 0; i < 300; i++) begin
         cnt_i = 4'd3;  step();
         cnt_i = 4'd12; step();
      end
      check("miss_saturated", int'(miss_cnt_o), 255);
      // Clear together with a fresh miss leaves just that miss.
      cnt_i = 4'd3; clr_miss_i = 1'b1; step();
      check("clr_with_miss", int'(miss_cnt_o), 1);

      // Sticky overflow gives one event; ack loses to a same-cycle set.
      cnt_i = 4'd5; ack_i = 3'b111; clr_miss_i = 1'b1; step();
      ack_i = 3'b000; clr_miss_i = 1'b0;
      cnt_ovf_i = 1'b1;
      repeat (10) step();
      check("ovf_sticky_pend", int'(pend_o), 3'b100);
      check("ovf_sticky_miss", int'(miss_cnt_o), 0);
      cnt_ovf_i = 1'b0; step();
      cnt_ovf_i = 1'b1; ack_i = 3'b100; step();
      check("ovf_set_beats_ack", int'(pend_o[2]), 1);
      check("ovf_set_ack_miss", int'(miss_cnt_o), 0);

      // Enabling above hi arms for LO silently; bad config idles the FSM.
      ack_i = 3'b111; cfg_en_i = 1'b0; cnt_ovf_i = 1'b0; step();
      ack_i = 3'b000; cnt_i = 4'd14; cfg_en_i = 1'b1; step(); step();
      check("arm_lo_no_hi", int'(pend_o), 0);
      cnt_i = 4'd2; step();
      check("armed_lo_fires", int'(pend_o), 3'b010);
      cfg_lo_i = 4'd12; #1;
      check("cfg_err_set", int'(cfg_err_o), 1);
      step(); step();
      cnt_i = 4'd14; step(); step();
      check("cfg_err_no_event", int'(pend_o), 3'b010);

      // Build pend=111, miss=5, then a single reset cycle.
      cfg_lo_i = 4'd3; cnt_i = 4'd0; clr_miss_i = 1'b1; step();
      clr_miss_i = 1'b0; step();
      cnt_i = 4'd12; step();
      for (int i = 0; i < 5; i++) begin
         cnt_i = (i % 2 == 0) ? 4'd3 : 4'd12;
         cnt_ovf_i = (i == 4);
         step();
      end
      check("pre_rst_pend", int'(pend_o), 3'b111);
      check("pre_rst_miss", int'(miss_cnt_o), 5);
      rst_i = 1'b1; step();
      rst_i = 1'b0;
      check("rst_pend", int'(pend_o), 0);
      check("rst_irq", int'(irq_o), 0);
      check("rst_miss", int'(miss_cnt_o), 0);

      // Randomized phase against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] h;
         h = 4'($urandom_range(1, 15));
         if ($urandom_range(0, 15) == 0) begin
            cfg_hi_i = h; cfg_lo_i = 4'($urandom_range(int'(h), 15));
         end else if ($urandom_range(0, 7) == 0) begin
            cfg_hi_i = h; cfg_lo_i = 4'($urandom_range(0, int'(h) - 1));
         end
         cfg_en_i   = ($urandom_range(0, 19) != 0);
         cnt_i      = 4'($urandom_range(0, 15));
         cnt_ovf_i  = ($urandom_range(0, 3) == 0) ? ~cnt_ovf_i : cnt_ovf_i;
         ack_i      = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         clr_miss_i = ($urandom_range(0, 49) == 0);
         rst_i      = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
